crossbar_arbiter: RTL and testbench
===================================

CROSSBAR_ARBITER -- requirements
Module: crossbar_arbiter

Interface
REQ-001 SHALL have parameter MAX_BEATS, default 64, meaning maximum beats per packet before forced release.
REQ-002 SHALL have parameter STALL_TIMEOUT, default 16, meaning consecutive idle cycles inside a granted packet before forced release.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; synchronous and active-low.
REQ-005 req_valid_0  input  1  port 0 beat valid; port 0 always targets output 1.
REQ-006 req_last_0  input  1  port 0 beat is the last beat of its packet.
REQ-007 req_valid_1  input  1  port 1 beat valid.
REQ-008 req_last_1  input  1  port 1 beat is the last beat of its packet.
REQ-009 req_bcast_1  input  1  port 1 packet targets both outputs (1) or output 0 only (0); sampled only on the first beat.
REQ-010 out_ready_0 / out_ready_1  input  1 each  downstream output 0 / output 1 can accept a beat.
REQ-011 control_crossbar  output  2  crossbar select: 00 idle, 01 port0->out1, 10 port1->out0, 11 port1->out0 and out1.
REQ-012 ready_0 / ready_1  output  1 each  a beat on port 0 / port 1 transfers this cycle.
REQ-013 out_valid_0 / out_valid_1  output  1 each  output 0 / output 1 carries a valid beat this cycle.
REQ-014 err_overlength / err_timeout  output  1 each  one-cycle pulse on forced release.

Function
REQ-015 SHALL implement FSM states IDLE, GNT_P0, GNT_P1, GNT_P1_BC; control_crossbar is decoded from the registered state: 00, 01, 10, 11 respectively.
REQ-016 In IDLE with exactly one requester, SHALL move to that requester's grant state on the next edge; port 1 SHALL enter GNT_P1_BC if req_bcast_1=1, otherwise GNT_P1.
REQ-017 In IDLE with both requesting, SHALL grant the port not served last (1-bit round-robin pointer); the pointer resets to favour port 0.
REQ-018 Arbitration latency: a request arriving in IDLE SHALL see the grant exactly one cycle later; no beat transfers in IDLE.
REQ-019 ready_0 = (state==GNT_P0) & out_ready_1; ready_1 = (GNT_P1 & out_ready_0) | (GNT_P1_BC & out_ready_0 & out_ready_1); all combinational from state and inputs.
REQ-020 out_valid_x SHALL be asserted only when the granted source's valid is high and every output selected by the state is ready; broadcast beats are all-or-nothing.
REQ-021 A transfer is valid & ready on the granted port; a transfer with last=1 SHALL return the FSM to IDLE on the next edge and set the pointer to favour the other port.
REQ-022 A grant SHALL be held, regardless of the other port's requests, until last transfers or a forced release occurs (no mid-packet preemption).
REQ-023 A beat counter (width clog2(MAX_BEATS+1)) SHALL clear on grant entry and increment per transfer; if the MAX_BEATS-th transfer is not last, SHALL return to IDLE and pulse err_overlength on the following cycle.
REQ-024 A stall counter SHALL count consecutive granted cycles with the source valid low, clear on any source-valid cycle, and on reaching STALL_TIMEOUT SHALL return to IDLE and pulse err_timeout.
REQ-025 Downstream backpressure (valid high, ready low) SHALL NOT advance the stall counter.
REQ-026 If last transfers in the same cycle that a counter limit is hit, the normal release SHALL take priority and no error SHALL pulse.
REQ-027 A single-beat packet (valid and last on the first granted cycle) SHALL occupy exactly one grant cycle plus one IDLE cycle.

Reset
REQ-028 While rst_n=0 at an edge: state=IDLE, control_crossbar=00, counters=0, pointer favours port 0, err pulses=0; ready and out_valid are consequently 0.
REQ-029 Reset asserted mid-packet SHALL abandon the packet without an error pulse; arbitration restarts from IDLE on the first edge after release.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding and the control_crossbar codes (CB_IDLE, CB_P0_TO_O1, CB_P1_TO_O0, CB_P1_BCAST), used by both this block and the crossbar.
REQ-031 The two-requester round-robin pick SHALL be one sub-module, rr_arb2 (inputs req[1:0], pointer; output one-hot grant).

Verification
REQ-032 Port 0 sends a 3-beat packet, outputs ready -> control 01 from cycle 1, ready_0 high for 3 cycles, control 00 in cycle 4.
REQ-033 Both ports request in IDLE after reset -> port 0 is granted first; after its last beat, port 1 is granted with no other request present.
REQ-034 Port 1 broadcast with out_ready_1 low for 2 cycles -> control 11, ready_1 and both out_valids low for those 2 cycles, stall counter unchanged.
REQ-035 Port 0 granted, valid drops for 16 cycles -> err_timeout pulses for one cycle, state returns to IDLE.
REQ-036 MAX_BEATS=4, port 1 sends 5 beats without last -> release after beat 4 with err_overlength; a 4-beat packet ending in last -> no error.
REQ-037 rst_n pulled low during beat 2 of a port 1 packet -> control 00 next cycle, no error pulses, clean regrant afterwards.

Source files
------------

// File: rtl/crossbar_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// crossbar_arbiter_pkg
// Shared definitions for the two-port crossbar arbiter and the crossbar it
// steers: FSM state encoding, crossbar select codes and the state-to-select
// decode.
// -----------------------------------------------------------------------------
package crossbar_arbiter_pkg;

  // Arbiter FSM states
  localparam logic [1:0] ST_IDLE      = 2'b00;
  localparam logic [1:0] ST_GNT_P0    = 2'b01;
  localparam logic [1:0] ST_GNT_P1    = 2'b10;
  localparam logic [1:0] ST_GNT_P1_BC = 2'b11;

  // Crossbar select codes
  localparam logic [1:0] CB_IDLE     = 2'b00;  // nothing routed
  localparam logic [1:0] CB_P0_TO_O1 = 2'b01;  // port 0 -> output 1
  localparam logic [1:0] CB_P1_TO_O0 = 2'b10;  // port 1 -> output 0
  localparam logic [1:0] CB_P1_BCAST = 2'b11;  // port 1 -> outputs 0 and 1

  function automatic logic [1:0] state_to_cb(input logic [1:0] st);
    logic [1:0] cb;
    cb = CB_IDLE;
    case (st)
      ST_GNT_P0:    cb = CB_P0_TO_O1;
      ST_GNT_P1:    cb = CB_P1_TO_O0;
      ST_GNT_P1_BC: cb = CB_P1_BCAST;
      default:      cb = CB_IDLE;
    endcase
    return cb;
  endfunction

endpackage

// File: rtl/crossbar_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin pick. Purely combinational.
//   req[1:0]   requesters (bit n = port n)
//   pointer    0: port 0 wins a tie, 1: port 1 wins a tie
//   grant[1:0] one-hot grant, zero when nobody requests
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       pointer,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = pointer ? 2'b10 : 2'b01;
    end else begin
      // Zero or one requester: the request vector is already one-hot.
      grant = req;
    end
  end

endmodule

// File: rtl/crossbar_arbiter.sv
// -----------------------------------------------------------------------------
// crossbar_arbiter
// Grants one of two packet sources to the output crossbar and holds the grant
// for the whole packet. Port 0 always goes to output 1; port 1 goes to output 0
// or, for broadcast packets, to both outputs.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid_0 / req_last_0   port 0 beat valid / last beat of packet
//   req_valid_1 / req_last_1   port 1 beat valid / last beat of packet
//   req_bcast_1                port 1 packet is broadcast (sampled in IDLE)
//   out_ready_0 / out_ready_1  downstream outputs can accept a beat
//   control_crossbar           crossbar select, a direct decode of the FSM
//                              state (00 IDLE, 01 P0, 10 P1, 11 P1 bcast)
//   ready_0 / ready_1          source-side ready
//   out_valid_0 / out_valid_1  output-side valid
//   err_overlength/err_timeout one-cycle pulse after a forced release
//
// Handshake: a beat transfers in a cycle when the granted source's valid and
// its ready are both high. ready depends only on the registered state and the
// downstream readies (never on valid); out_valid is valid AND ready, so a
// broadcast beat is presented to both outputs or to neither.
// -----------------------------------------------------------------------------
module crossbar_arbiter
  import crossbar_arbiter_pkg::*;
#(
  parameter int MAX_BEATS     = 64,
  parameter int STALL_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid_0,
  input  logic       req_last_0,
  input  logic       req_valid_1,
  input  logic       req_last_1,
  input  logic       req_bcast_1,
  input  logic       out_ready_0,
  input  logic       out_ready_1,
  output logic [1:0] control_crossbar,
  output logic       ready_0,
  output logic       ready_1,
  output logic       out_valid_0,
  output logic       out_valid_1,
  output logic       err_overlength,
  output logic       err_timeout
);

  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam int SW = $clog2(STALL_TIMEOUT + 1);
  // Counter values seen in the cycle that hits the limit.
  localparam logic [BW-1:0] BEAT_LAST  = BW'(MAX_BEATS - 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_TIMEOUT - 1);

  logic [1:0]    state, state_nx;
  logic [BW-1:0] beat_cnt, beat_nx;
  logic [SW-1:0] stall_cnt, stall_nx;
  logic          ptr, ptr_nx;
  logic          eo_nx, et_nx;
  logic [1:0]    grant;

  logic in_p0, in_p1;  // in_p1 covers both unicast and broadcast grants
  logic src_valid, src_last, xfer;

  rr_arb2 u_rr_arb2 (
    .req     ({req_valid_1, req_valid_0}),
    .pointer (ptr),
    .grant   (grant)
  );

  assign in_p0 = (state == ST_GNT_P0);
  assign in_p1 = (state == ST_GNT_P1) || (state == ST_GNT_P1_BC);

  assign control_crossbar = state_to_cb(state);
  assign ready_0     = in_p0 & out_ready_1;
  assign ready_1     = ((state == ST_GNT_P1) & out_ready_0) |
                       ((state == ST_GNT_P1_BC) & out_ready_0 & out_ready_1);
  assign out_valid_0 = req_valid_1 & ready_1;
  assign out_valid_1 = (req_valid_0 & ready_0) |
                       ((state == ST_GNT_P1_BC) & req_valid_1 & ready_1);

  assign src_valid = (in_p0 & req_valid_0) | (in_p1 & req_valid_1);
  assign src_last  = (in_p0 & req_last_0)  | (in_p1 & req_last_1);
  assign xfer      = (req_valid_0 & ready_0) | (req_valid_1 & ready_1);

  always_comb begin
    state_nx = state;
    beat_nx  = beat_cnt;
    stall_nx = stall_cnt;
    ptr_nx   = ptr;
    eo_nx    = 1'b0;
    et_nx    = 1'b0;
    if (state == ST_IDLE) begin
      beat_nx  = '0;
      stall_nx = '0;
      if (grant[0]) begin
        state_nx = ST_GNT_P0;
      end else if (grant[1]) begin
        state_nx = req_bcast_1 ? ST_GNT_P1_BC : ST_GNT_P1;
      end
    end else begin
      // Only a missing source beat counts as a stall; backpressure does not.
      stall_nx = src_valid ? '0 : stall_cnt + 1'b1;
      if (xfer) begin
        beat_nx = beat_cnt + 1'b1;
      end
      // Normal release is checked first so a last beat on the limit is clean.
      if (xfer && src_last) begin
        state_nx = ST_IDLE;
        ptr_nx   = in_p0;
      end else if (xfer && (beat_cnt == BEAT_LAST)) begin
        state_nx = ST_IDLE;
        ptr_nx   = in_p0;
        eo_nx    = 1'b1;
      end else if (!src_valid && (stall_cnt == STALL_LAST)) begin
        state_nx = ST_IDLE;
        ptr_nx   = in_p0;
        et_nx    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      beat_cnt       <= '0;
      stall_cnt      <= '0;
      ptr            <= 1'b0;
      err_overlength <= 1'b0;
      err_timeout    <= 1'b0;
    end else begin
      state          <= state_nx;
      beat_cnt       <= beat_nx;
      stall_cnt      <= stall_nx;
      ptr            <= ptr_nx;
      err_overlength <= eo_nx;
      err_timeout    <= et_nx;
    end
  end

endmodule

// File: tb/tb_crossbar_arbiter.sv
// -----------------------------------------------------------------------------
// tb_crossbar_arbiter
// Directed bench for crossbar_arbiter (MAX_BEATS=4, STALL_TIMEOUT=16).
// Each cycle drives the inputs at the falling edge, queues the outputs that
// cycle must show, and compares them 3 ns later, before the next rising edge.
// Output vector: {control_crossbar[1:0], ready_0, ready_1, out_valid_0,
//                 out_valid_1, err_overlength, err_timeout}
// -----------------------------------------------------------------------------
module tb_crossbar_arbiter;

  localparam int W = 8;

  logic       clk;
  logic       rst_n;
  logic       req_valid_0, req_last_0;
  logic       req_valid_1, req_last_1, req_bcast_1;
  logic       out_ready_0, out_ready_1;
  logic [1:0] control_crossbar;
  logic       ready_0, ready_1;
  logic       out_valid_0, out_valid_1;
  logic       err_overlength, err_timeout;

  logic [W-1:0] exp_q[$];
  int tests_run;
  int tests_failed;

  crossbar_arbiter #(
    .MAX_BEATS     (4),
    .STALL_TIMEOUT (16)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid_0      (req_valid_0),
    .req_last_0       (req_last_0),
    .req_valid_1      (req_valid_1),
    .req_last_1       (req_last_1),
    .req_bcast_1      (req_bcast_1),
    .out_ready_0      (out_ready_0),
    .out_ready_1      (out_ready_1),
    .control_crossbar (control_crossbar),
    .ready_0          (ready_0),
    .ready_1          (ready_1),
    .out_valid_0      (out_valid_0),
    .out_valid_1      (out_valid_1),
    .err_overlength   (err_overlength),
    .err_timeout      (err_timeout)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W-1:0] e(input logic [1:0] cb, input logic r0,
                                     input logic r1, input logic ov0,
                                     input logic ov1, input logic eo,
                                     input logic et);
    return {cb, r0, r1, ov0, ov1, eo, et};
  endfunction

  // Scoreboard check: pop the oldest expectation and compare.
  task automatic check(input string tag);
    logic [W-1:0] obs;
    logic [W-1:0] exp_v;
    obs   = {control_crossbar, ready_0, ready_1, out_valid_0, out_valid_1,
             err_overlength, err_timeout};
    exp_v = exp_q.pop_front();
    tests_run++;
    assert (obs === exp_v) else begin
      tests_failed++;
      $error("FAIL %s: observed %b expected %b (cb,r0,r1,ov0,ov1,eo,et)",
             tag, obs, exp_v);
    end
  endtask

  // Driver: one cycle of stimulus, called at a falling edge.
  task automatic cyc(input string tag, input logic rst, input logic v0,
                     input logic l0, input logic v1, input logic l1,
                     input logic b1, input logic o0, input logic o1,
                     input logic [W-1:0] exp_v);
    rst_n       = rst;
    req_valid_0 = v0;
    req_last_0  = l0;
    req_valid_1 = v1;
    req_last_1  = l1;
    req_bcast_1 = b1;
    out_ready_0 = o0;
    out_ready_1 = o1;
    exp_q.push_back(exp_v);
    #3;
    check(tag);
    @(negedge clk);
  endtask

  localparam logic [W-1:0] Z = 8'b0;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    req_valid_0  = 1'b0;
    req_last_0   = 1'b0;
    req_valid_1  = 1'b0;
    req_last_1   = 1'b0;
    req_bcast_1  = 1'b0;
    out_ready_0  = 1'b1;
    out_ready_1  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state, even with requests present
    cyc("rst_idle",   0, 1,0, 1,0,0, 1,1, Z);
    cyc("rst_hold",   0, 1,0, 1,0,1, 1,1, Z);

    // Port 0, 3-beat packet
    cyc("p0_req",     1, 1,0, 0,0,0, 1,1, Z);
    cyc("p0_beat1",   1, 1,0, 0,0,0, 1,1, e(2'b01,1,0,0,1,0,0));
    cyc("p0_beat2",   1, 1,0, 0,0,0, 1,1, e(2'b01,1,0,0,1,0,0));
    cyc("p0_beat3",   1, 1,1, 0,0,0, 1,1, e(2'b01,1,0,0,1,0,0));
    cyc("p0_done",    1, 0,0, 0,0,0, 1,1, Z);

    // Pointer now favours port 1: tie goes to port 1, single-beat packet
    cyc("rr_tie",     1, 1,0, 1,0,0, 1,1, Z);
    cyc("rr_p1_win",  1, 1,0, 1,1,0, 1,1, e(2'b10,0,1,1,0,0,0));
    cyc("rr_p1_idle", 1, 0,0, 0,0,0, 1,1, Z);

    // After reset both request: port 0 first, then port 1
    cyc("both_rst",   0, 0,0, 0,0,0, 1,1, Z);
    cyc("both_req",   1, 1,0, 1,0,0, 1,1, Z);
    cyc("both_p0",    1, 1,1, 1,0,0, 1,1, e(2'b01,1,0,0,1,0,0));
    cyc("both_idle",  1, 0,0, 1,0,0, 1,1, Z);
    cyc("both_p1",    1, 0,0, 1,1,0, 1,1, e(2'b10,0,1,1,0,0,0));
    cyc("both_done",  1, 0,0, 0,0,0, 1,1, Z);

    // Port 1 broadcast under backpressure on output 1 (longer than timeout)
    cyc("bc_req",     1, 0,0, 1,0,1, 1,1, Z);
    for (int i = 0; i < 18; i++)
      cyc("bc_stall", 1, 0,0, 1,0,0, 1,0, e(2'b11,0,0,0,0,0,0));
    cyc("bc_oready0", 1, 0,0, 1,0,0, 0,1, e(2'b11,0,0,0,0,0,0));
    cyc("bc_beat1",   1, 0,0, 1,0,0, 1,1, e(2'b11,0,1,1,1,0,0));
    cyc("bc_beat2",   1, 0,0, 1,1,0, 1,1, e(2'b11,0,1,1,1,0,0));
    cyc("bc_done",    1, 0,0, 0,0,0, 1,1, Z);

    // Port 0 stall timeout; a valid beat after 10 idle cycles restarts it
    cyc("to_req",     1, 1,0, 0,0,0, 1,1, Z);
    cyc("to_beat1",   1, 1,0, 0,0,0, 1,1, e(2'b01,1,0,0,1,0,0));
    for (int i = 0; i < 10; i++)
      cyc("to_gap",   1, 0,0, 0,0,0, 1,1, e(2'b01,1,0,0,0,0,0));
    cyc("to_beat2",   1, 1,0, 0,0,0, 1,1, e(2'b01,1,0,0,1,0,0));
    for (int i = 0; i < 16; i++)
      cyc("to_idle",  1, 0,0, 0,0,0, 1,1, e(2'b01,1,0,0,0,0,0));
    cyc("to_pulse",   1, 0,0, 0,0,0, 1,1, e(2'b00,0,0,0,0,0,1));
    cyc("to_clear",   1, 0,0, 0,0,0, 1,1, Z);

    // Port 1 overlength: beat 4 without last forces release
    cyc("ol_req",     1, 0,0, 1,0,0, 1,1, Z);
    for (int i = 0; i < 4; i++)
      cyc("ol_beat",  1, 0,0, 1,0,0, 1,1, e(2'b10,0,1,1,0,0,0));
    cyc("ol_pulse",   1, 0,0, 1,0,0, 1,1, e(2'b00,0,0,0,0,1,0));
    // Regranted: exactly 4 beats ending in last is not an error
    for (int i = 0; i < 3; i++)
      cyc("ok4_beat", 1, 0,0, 1,0,0, 1,1, e(2'b10,0,1,1,0,0,0));
    cyc("ok4_last",   1, 0,0, 1,1,0, 1,1, e(2'b10,0,1,1,0,0,0));
    cyc("ok4_noerr",  1, 0,0, 0,0,0, 1,1, Z);

    // Reset during beat 2 of a port 1 packet
    cyc("mr_req",     1, 0,0, 1,0,0, 1,1, Z);
    cyc("mr_beat1",   1, 0,0, 1,0,0, 1,1, e(2'b10,0,1,1,0,0,0));
    cyc("mr_beat2",   0, 0,0, 1,0,0, 1,1, e(2'b10,0,1,1,0,0,0));
    cyc("mr_after",   1, 0,0, 0,0,0, 1,1, Z);
    cyc("mr_tie",     1, 1,0, 1,0,0, 1,1, Z);
    cyc("mr_regrant", 1, 1,1, 1,0,0, 1,1, e(2'b01,1,0,0,1,0,0));
    cyc("mr_done",    1, 0,0, 0,0,0, 1,1, Z);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
